// File: rtl/sensor_interval_timer_pkg.sv
// Shared definitions for the sensor interval timer and the arrival-time predictor.
package sensor_interval_timer_pkg;

   // Width of the interval word handed to the predictor
   localparam int unsigned TIME_W = 19;

   // Measurement controller states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/sensor_interval_timer_sync.sv
// Two-flop synchroniser followed by a registered rising-edge detector for one raw sensor line.
module sensor_sync_edge (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic pulse
);

   logic sync0;
   logic sync1;
   logic prev;

   // Synchronise the raw line and emit one pulse per 0->1 transition
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync0 <= 1'b0;
         sync1 <= 1'b0;
         prev  <= 1'b0;
         pulse <= 1'b0;
      end else begin
         sync0 <= din;
         sync1 <= sync0;
         prev  <= sync1;
         pulse <= sync1 & ~prev;
      end
   end

endmodule

// File: rtl/sensor_interval_timer.sv
// Measures the S1->S2 interval in whole milliseconds and reports it to the predictor,
// or flags a timeout when S2 does not arrive.
module sensor_interval_timer
   import sensor_interval_timer_pkg::*;
#(
   parameter int unsigned TICK_DIV   = 50000,
   parameter int unsigned WIDTH      = TIME_W,
   parameter int unsigned TIMEOUT_MS = 500000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             s1,
   input  logic             s2,
   output logic [WIDTH-1:0] time_ms,
   output logic             time_valid,
   output logic             timeout,
   output logic             busy
);

   localparam int unsigned      PW         = $clog2(TICK_DIV);
   localparam logic [PW-1:0]    PRESC_LAST = PW'(TICK_DIV - 1);
   localparam logic [WIDTH-1:0] MS_LAST    = WIDTH'(TIMEOUT_MS - 1);
   localparam logic [WIDTH-1:0] MS_ONE     = WIDTH'(1);

   state_t           state;
   logic [PW-1:0]    presc;
   logic [WIDTH-1:0] ms_cnt;
   logic [WIDTH-1:0] ms_now;
   logic [WIDTH-1:0] captured;
   logic             wrap;
   logic             e1;
   logic             e2;

   sensor_sync_edge u_sync_s1 (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (s1),
      .pulse (e1)
   );

   sensor_sync_edge u_sync_s2 (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (s2),
      .pulse (e2)
   );

   // Elapsed ms as of this edge, counting a tick that completes on this same edge,
   // so a capture reflects the whole milliseconds since the e1 cycle
   always_comb begin
      wrap     = (presc == PRESC_LAST);
      ms_now   = wrap ? (ms_cnt + MS_ONE) : ms_cnt;
      captured = (ms_now == '0) ? MS_ONE : ms_now;
   end

   // Measurement FSM with prescaler, ms counter and registered outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         presc      <= '0;
         ms_cnt     <= '0;
         time_ms    <= '0;
         time_valid <= 1'b0;
         timeout    <= 1'b0;
         busy       <= 1'b0;
      end else begin
         time_valid <= 1'b0;
         timeout    <= 1'b0;
         case (state)
            IDLE: begin
               if (e1) begin
                  state  <= ARMED;
                  presc  <= '0;
                  ms_cnt <= '0;
                  busy   <= 1'b1;
               end
            end
            ARMED: begin
               if (e2) begin
                  state      <= DONE;
                  time_ms    <= captured;
                  time_valid <= 1'b1;
                  busy       <= 1'b0;
               end else if (e1) begin
                  presc  <= '0;
                  ms_cnt <= '0;
               end else begin
                  presc <= wrap ? '0 : presc + 1'b1;
                  if (wrap) begin
                     ms_cnt <= ms_now;
                     if (ms_cnt == MS_LAST) begin
                        timeout <= 1'b1;
                        state   <= IDLE;
                        busy    <= 1'b0;
                     end
                  end
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
